// File: rtl/core_run_sequencer.sv
// core_run_sequencer: boots and supervises a single-cycle RISC-V core.
// Streams a program image into instruction memory, holds the core in reset
// while loading, releases it with a latched start PC, then watches the core's
// fin flag and a run-cycle watchdog, reporting done/timeout/cycle_count.
// Optional feature macro: SEQ_LOAD_CHECKSUM_EN adds an XOR checksum of all
// loaded words on port load_checksum.
module core_run_sequencer #(
  parameter int WIDTH   = 32,
  parameter int IADDR   = 16,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [IADDR-1:0] load_base,
  input  logic [15:0]      load_len,
  input  logic [WIDTH-1:0] init_pc_in,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             imem_we,
  output logic [IADDR-1:0] imem_waddr,
  output logic [WIDTH-1:0] imem_wdata,
  output logic             core_reset_n,
  output logic [WIDTH-1:0] core_init_pc,
  input  logic             core_fin,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
`ifdef SEQ_LOAD_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0] load_checksum
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Watchdog fires when the count is one short of the limit in a RUN cycle,
  // so the count read in DONE equals the number of RUN cycles.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT);

  state_t             state_r;
  state_t             state_nx_s;
  logic               take_start_s;
  logic               hs_s;
  logic               fin_end_s;
  logic               wd_end_s;
  logic [IADDR-1:0]   addr_r;
  logic [15:0]        remain_r;
  logic               s_ready_r;
  logic               imem_we_r;
  logic [IADDR-1:0]   imem_waddr_r;
  logic [WIDTH-1:0]   imem_wdata_r;
  logic               core_reset_n_r;
  logic [WIDTH-1:0]   core_init_pc_r;
  logic               done_r;
  logic               timeout_r;
  logic [CNT_W-1:0]   cycle_count_r;

  // s_ready_r is only ever 1 while in LOAD, so it doubles as the LOAD qualifier.
  assign hs_s = s_ready_r & s_valid;

  // Next-state decode, start acceptance and run-termination conditions.
  always_comb begin
    state_nx_s   = state_r;
    take_start_s = 1'b0;
    fin_end_s    = 1'b0;
    wd_end_s     = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          take_start_s = 1'b1;
          state_nx_s   = (load_len != 16'd0) ? ST_LOAD : ST_RELEASE;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_LOAD: begin
        if (hs_s && (remain_r == 16'd1)) begin
          state_nx_s = ST_RELEASE;
        end else begin
          state_nx_s = ST_LOAD;
        end
      end
      ST_RELEASE: begin
        state_nx_s = ST_RUN;
      end
      ST_RUN: begin
        if (core_fin) begin
          fin_end_s  = 1'b1;
          state_nx_s = ST_DONE;
        end else if (cycle_count_r == TMO_LAST) begin
          wd_end_s   = 1'b1;
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
    // Abort overrides everything, including a simultaneous start.
    if (abort) begin
      state_nx_s   = ST_IDLE;
      take_start_s = 1'b0;
      fin_end_s    = 1'b0;
      wd_end_s     = 1'b0;
    end else begin
      state_nx_s = state_nx_s;
    end
  end

  // State register plus the state-derived registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      s_ready_r      <= 1'b0;
      core_reset_n_r <= 1'b0;
    end else begin
      state_r        <= state_nx_s;
      s_ready_r      <= (state_nx_s == ST_LOAD);
      core_reset_n_r <= (state_nx_s == ST_RUN);
    end
  end

  // Load bookkeeping: latched parameters, write address and words remaining.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r         <= {IADDR{1'b0}};
      remain_r       <= 16'd0;
      core_init_pc_r <= {WIDTH{1'b0}};
    end else if (take_start_s) begin
      addr_r         <= {load_base[IADDR-1:2], 2'b00};
      remain_r       <= load_len;
      core_init_pc_r <= init_pc_in;
    end else if (hs_s) begin
      addr_r   <= addr_r + IADDR'(4);
      remain_r <= remain_r - 16'd1;
    end
  end

  // Registered imem write port; a handshake in an abort cycle still lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_we_r    <= 1'b0;
      imem_waddr_r <= {IADDR{1'b0}};
      imem_wdata_r <= {WIDTH{1'b0}};
    end else begin
      imem_we_r <= hs_s;
      if (hs_s) begin
        imem_waddr_r <= addr_r;
        imem_wdata_r <= s_data;
      end
    end
  end

  // Run supervision: saturating cycle counter and sticky done/timeout flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_r        <= 1'b0;
      timeout_r     <= 1'b0;
      cycle_count_r <= {CNT_W{1'b0}};
    end else if (abort || take_start_s) begin
      done_r        <= 1'b0;
      timeout_r     <= 1'b0;
      cycle_count_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_RUN) begin
      if (cycle_count_r != TMO_MAX) begin
        cycle_count_r <= cycle_count_r + CNT_W'(1);
      end
      if (fin_end_s || wd_end_s) begin
        done_r    <= 1'b1;
        timeout_r <= wd_end_s;
      end
    end
  end

`ifdef SEQ_LOAD_CHECKSUM_EN
  logic [WIDTH-1:0] load_checksum_r;

  // XOR of every word accepted during the load; cleared by start or abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_checksum_r <= {WIDTH{1'b0}};
    end else if (abort || take_start_s) begin
      load_checksum_r <= {WIDTH{1'b0}};
    end else if (hs_s) begin
      load_checksum_r <= load_checksum_r ^ s_data;
    end
  end

  assign load_checksum = load_checksum_r;
`endif

  assign s_ready      = s_ready_r;
  assign imem_we      = imem_we_r;
  assign imem_waddr   = imem_waddr_r;
  assign imem_wdata   = imem_wdata_r;
  assign core_reset_n = core_reset_n_r;
  assign core_init_pc = core_init_pc_r;
  assign done         = done_r;
  assign timeout      = timeout_r;
  assign cycle_count  = cycle_count_r;
  assign busy         = (state_r == ST_LOAD) || (state_r == ST_RELEASE) || (state_r == ST_RUN);

endmodule
